// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the keypad encoder.
//   kp_state_e : encoder FSM state (IDLE / DEBOUNCE / HELD / RELEASE)
//   kp_prio_t  : result of kp_prio (any key, highest index, more-than-one)
//   kp_prio()  : priority encode + popcount>1 over a KP_MAX_KEYS-wide vector
// Narrower keypads are zero-extended to KP_MAX_KEYS before calling kp_prio,
// so NUM_KEYS must not exceed KP_MAX_KEYS.
// ----------------------------------------------------------------------------
package keypad_pkg;

    localparam int KP_MAX_KEYS = 32;
    localparam int KP_CODE_W   = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_e;

    typedef struct packed {
        logic                 valid;
        logic [KP_CODE_W-1:0] code;
        logic                 multi;
    } kp_prio_t;

    // Highest asserted index wins; the count saturates at 2 since only
    // "more than one" is of interest.
    function automatic kp_prio_t kp_prio(input logic [KP_MAX_KEYS-1:0] keys);
        kp_prio_t r;
        int       n;
        r = '0;
        n = 0;
        for (int i = 0; i < KP_MAX_KEYS; i++) begin
            if (keys[i]) begin
                r.valid = 1'b1;
                r.code  = KP_CODE_W'(i);
                if (n < 2) n = n + 1;
            end
        end
        r.multi = (n > 1);
        return r;
    endfunction

endpackage

// File: rtl/keypad_encoder_db_tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Free-running square wave: pgt_1Hz toggles every HALF_PERIOD clk cycles.
//   clk     : system clock
//   rst     : asynchronous active-high reset (pgt_1Hz = 0, counter = 0)
//   pgt_1Hz : square wave output, period 2*HALF_PERIOD cycles
// ----------------------------------------------------------------------------
module tick_gen #(
    parameter int HALF_PERIOD = 25
) (
    input  logic clk,
    input  logic rst,
    output logic pgt_1Hz
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pgt_q, pgt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        pgt_d = pgt_q;
        if (cnt_q == CW'(HALF_PERIOD - 1)) begin
            cnt_d = '0;
            pgt_d = ~pgt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            pgt_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pgt_q <= pgt_d;
        end
    end

    assign pgt_1Hz = pgt_q;

endmodule

// File: rtl/keypad_encoder_db.sv
// ----------------------------------------------------------------------------
// keypad_encoder_db
// Debounced priority keypad encoder with load strobe and timer tick.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   keypad    : raw key lines (NUM_KEYS), 1 = pressed, may bounce
//   enablen   : active-low enable; high forces the encoder idle
//   D         : code of the last accepted key (CODE_W)
//   loadn     : active-low one-cycle strobe, D valid while low
//   multi_key : registered, high while more than one key line is asserted
//   pgt_1Hz   : square wave, period 2*HALF_PERIOD cycles
// Optional: define KEYPAD_AUTOREPEAT_EN to add held-key auto-repeat
// (REPEAT_DELAY cycles to first repeat, then every REPEAT_PERIOD cycles).
// ----------------------------------------------------------------------------
module keypad_encoder_db
    import keypad_pkg::*;
#(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HALF_PERIOD     = 25
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                enablen,
    output logic [CODE_W-1:0]   D,
    output logic                loadn,
    output logic                multi_key,
    output logic                pgt_1Hz
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [KP_MAX_KEYS-1:0] keys_ext;
    kp_prio_t               prio;
    logic [CODE_W-1:0]      cand_code;
    logic                   unused_prio_code;

    kp_state_e         state_q, state_d;
    logic [CODE_W-1:0] code_q,  code_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [CODE_W-1:0] dout_q,  dout_d;
    logic              loadn_q, loadn_d;
    logic              multi_q, multi_d;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_first_q, rpt_first_d;  // still waiting for the first repeat
`endif

    assign keys_ext         = KP_MAX_KEYS'(keypad);
    assign prio             = kp_prio(keys_ext);
    assign cand_code        = CODE_W'(prio.code);
    assign unused_prio_code = ^prio.code;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        loadn_d = 1'b1;
        multi_d = prio.multi;
`ifdef KEYPAD_AUTOREPEAT_EN
        // Repeat tracking clears whenever the FSM is not sitting in HELD.
        rpt_d       = '0;
        rpt_first_d = 1'b1;
`endif
        if (enablen) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (prio.valid) begin
                        code_d  = cand_code;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!prio.valid) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (cand_code != code_q) begin
                        code_d = cand_code;
                        cnt_d  = '0;
                    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        dout_d  = code_q;
                        loadn_d = 1'b0;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    // A different key while held is ignored until full release.
                    if (!prio.valid) begin
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                        rpt_first_d = rpt_first_q;
                        if (rpt_first_q ? (rpt_q == RPT_W'(REPEAT_DELAY - 1))
                                        : (rpt_q == RPT_W'(REPEAT_PERIOD - 1))) begin
                            loadn_d     = 1'b0;
                            rpt_d       = '0;
                            rpt_first_d = 1'b0;
                        end else begin
                            rpt_d = rpt_q + 1'b1;
                        end
`endif
                    end
                end
                RELEASE: begin
                    // Re-assertion here is release bounce: back to HELD, no strobe.
                    if (prio.valid) begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            loadn_q <= 1'b1;
            multi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            loadn_q <= loadn_d;
            multi_q <= multi_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_q       <= rpt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    tick_gen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_tick_gen (
        .clk     (clk),
        .rst     (rst),
        .pgt_1Hz (pgt_1Hz)
    );

    assign D         = dout_q;
    assign loadn     = loadn_q;
    assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_encoder_db.sv
// ----------------------------------------------------------------------------
// tb_keypad_encoder_db
// Directed self-checking bench for keypad_encoder_db with default parameters
// (NUM_KEYS=10, CODE_W=4, DEBOUNCE_CYCLES=4, HALF_PERIOD=25).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so sample k is the state after the k-th edge since the change.
// ----------------------------------------------------------------------------
module tb_keypad_encoder_db;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] keypad;
    logic       enablen;
    logic [3:0] D;
    logic       loadn;
    logic       multi_key;
    logic       pgt_1Hz;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_encoder_db dut (
        .clk       (clk),
        .rst       (rst),
        .keypad    (keypad),
        .enablen   (enablen),
        .D         (D),
        .loadn     (loadn),
        .multi_key (multi_key),
        .pgt_1Hz   (pgt_1Hz)
    );

    // Advance n cycles, counting loadn-low samples and when they occur.
    task automatic run_cycles(input int n, output int pulses, output int first_at,
                              output int last_at, output logic [3:0] d_at_first);
        pulses     = 0;
        first_at   = -1;
        last_at    = -1;
        d_at_first = 4'hF;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (loadn === 1'b0) begin
                if (pulses == 0) begin
                    first_at   = k;
                    d_at_first = D;
                end
                last_at = k;
                pulses  = pulses + 1;
            end
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        keypad  = '0;
        enablen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (D !== 4'd0)        begin errors++; $display("FAIL reset_D got %0d want 0", D); end
        checks++; if (loadn !== 1'b1)    begin errors++; $display("FAIL reset_loadn got %b want 1", loadn); end
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL reset_multi got %b want 0", multi_key); end
        checks++; if (pgt_1Hz !== 1'b0)  begin errors++; $display("FAIL reset_pgt got %b want 0", pgt_1Hz); end
        rst = 1'b0;
    endtask

    // Starts right after reset release: toggles land on samples 25, 50, 75, 100.
    task automatic test_tick;
        int          sample_k [8] = '{24, 25, 49, 50, 74, 75, 99, 100};
        logic        sample_v [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int          idx;
        idx = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            enablen = (k >= 30 && k < 80);  // tick must ignore enable
            if (idx < 8 && k == sample_k[idx]) begin
                checks++;
                if (pgt_1Hz !== sample_v[idx]) begin
                    errors++;
                    $display("FAIL tick_k%0d got %b want %b", k, pgt_1Hz, sample_v[idx]);
                end
                idx++;
            end
        end
        enablen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single_press;
        int p, f, l;
        logic [3:0] dv;
        keypad = 10'b1 << 5;
        run_cycles(10, p, f, l, dv);
        checks++; if (p != 1)        begin errors++; $display("FAIL single_pulses got %0d want 1", p); end
        checks++; if (f != 5)        begin errors++; $display("FAIL single_latency got %0d want 5", f); end
        checks++; if (dv !== 4'd5)   begin errors++; $display("FAIL single_D got %0d want 5", dv); end
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL single_multi got %b want 0", multi_key); end
        keypad = '0;
        run_cycles(10, p, f, l, dv);
        checks++; if (p != 0)        begin errors++; $display("FAIL single_release_pulses got %0d want 0", p); end
        checks++; if (D !== 4'd5)    begin errors++; $display("FAIL single_hold_D got %0d want 5", D); end
    endtask

    task automatic test_bounce;
        int p, f, l, total;
        logic [3:0] dv;
        total = 0;
        for (int b = 0; b < 3; b++) begin
            keypad = 10'b1 << 1;
            run_cycles(2, p, f, l, dv);
            total += p;
            keypad = '0;
            run_cycles(2, p, f, l, dv);
            total += p;
        end
        checks++; if (total != 0)    begin errors++; $display("FAIL bounce_pulses got %0d want 0", total); end
        keypad = 10'b1 << 1;
        run_cycles(6, p, f, l, dv);
        checks++; if (p != 1)        begin errors++; $display("FAIL bounce_stable_pulses got %0d want 1", p); end
        checks++; if (f != 5)        begin errors++; $display("FAIL bounce_latency got %0d want 5", f); end
        checks++; if (dv !== 4'd1)   begin errors++; $display("FAIL bounce_D got %0d want 1", dv); end
        keypad = '0;
        run_cycles(8, p, f, l, dv);
    endtask

    task automatic test_multi_key;
        int p, f, l;
        logic [3:0] dv;
        keypad = (10'b1 << 3) | (10'b1 << 7);
        @(posedge clk);
        #1;
        checks++; if (multi_key !== 1'b1) begin errors++; $display("FAIL multi_flag got %b want 1", multi_key); end
        run_cycles(7, p, f, l, dv);
        checks++; if (p != 1)        begin errors++; $display("FAIL multi_pulses got %0d want 1", p); end
        checks++; if (f != 4)        begin errors++; $display("FAIL multi_latency got %0d want 4", f); end
        checks++; if (dv !== 4'd7)   begin errors++; $display("FAIL multi_D got %0d want 7", dv); end
        keypad = 10'b1 << 3;
        run_cycles(8, p, f, l, dv);
        checks++; if (p != 0)        begin errors++; $display("FAIL multi_drop_pulses got %0d want 0", p); end
        checks++; if (D !== 4'd7)    begin errors++; $display("FAIL multi_drop_D got %0d want 7", D); end
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL multi_clear got %b want 0", multi_key); end
        keypad = '0;
        run_cycles(8, p, f, l, dv);
    endtask

    task automatic test_enable;
        int p, f, l;
        logic [3:0] dv;
        keypad = 10'b1 << 2;
        run_cycles(2, p, f, l, dv);
        enablen = 1'b1;
        run_cycles(6, p, f, l, dv);
        checks++; if (p != 0)        begin errors++; $display("FAIL enable_abort_pulses got %0d want 0", p); end
        checks++; if (D !== 4'd7)    begin errors++; $display("FAIL enable_abort_D got %0d want 7", D); end
        enablen = 1'b0;
        run_cycles(8, p, f, l, dv);
        checks++; if (p != 1)        begin errors++; $display("FAIL enable_resume_pulses got %0d want 1", p); end
        checks++; if (f != 5)        begin errors++; $display("FAIL enable_resume_latency got %0d want 5", f); end
        checks++; if (dv !== 4'd2)   begin errors++; $display("FAIL enable_resume_D got %0d want 2", dv); end
        keypad = '0;
        run_cycles(8, p, f, l, dv);
    endtask

    task automatic test_hold_long;
        int p, f, l;
        logic [3:0] dv;
        keypad = 10'b1 << 4;
        run_cycles(100, p, f, l, dv);
`ifdef KEYPAD_AUTOREPEAT_EN
        // Initial strobe at 5, repeats at 55, 65, 75, 85, 95.
        checks++; if (p != 6)        begin errors++; $display("FAIL hold_pulses got %0d want 6", p); end
        checks++; if (l != 95)       begin errors++; $display("FAIL hold_last got %0d want 95", l); end
`else
        checks++; if (p != 1)        begin errors++; $display("FAIL hold_pulses got %0d want 1", p); end
`endif
        checks++; if (f != 5)        begin errors++; $display("FAIL hold_latency got %0d want 5", f); end
        checks++; if (D !== 4'd4)    begin errors++; $display("FAIL hold_D got %0d want 4", D); end
        keypad = '0;
        run_cycles(8, p, f, l, dv);
    endtask

    task automatic test_async_reset;
        int p, f, l;
        logic [3:0] dv;
        keypad = (10'b1 << 3) | (10'b1 << 6);
        run_cycles(4, p, f, l, dv);
        @(posedge clk);
        #1;
        checks++; if (loadn !== 1'b0)     begin errors++; $display("FAIL arst_pre_loadn got %b want 0", loadn); end
        checks++; if (D !== 4'd6)         begin errors++; $display("FAIL arst_pre_D got %0d want 6", D); end
        checks++; if (multi_key !== 1'b1) begin errors++; $display("FAIL arst_pre_multi got %b want 1", multi_key); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (loadn !== 1'b1)     begin errors++; $display("FAIL arst_loadn got %b want 1", loadn); end
        checks++; if (D !== 4'd0)         begin errors++; $display("FAIL arst_D got %0d want 0", D); end
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL arst_multi got %b want 0", multi_key); end
        checks++; if (pgt_1Hz !== 1'b0)   begin errors++; $display("FAIL arst_pgt got %b want 0", pgt_1Hz); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_cycles(8, p, f, l, dv);
        checks++; if (p != 1)        begin errors++; $display("FAIL arst_after_pulses got %0d want 1", p); end
        checks++; if (f != 5)        begin errors++; $display("FAIL arst_after_latency got %0d want 5", f); end
        checks++; if (dv !== 4'd6)   begin errors++; $display("FAIL arst_after_D got %0d want 6", dv); end
        keypad = '0;
        run_cycles(8, p, f, l, dv);
    endtask

    initial begin
        test_reset();
        test_tick();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_enable();
        test_hold_long();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

endmodule
